// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor controller.
// The state encoding and the op encoding live here.
package serial_addsub_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage : serial_addsub_ctrl_pkg

// File: rtl/serial_addsub_ctrl_fa_cell.sv
// One-bit add/subtract cell: a full adder whose b input is inverted when op=1.
// Purely combinational; the controller supplies the carry-in and holds the carry-out.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic op,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic b_eff;

    assign b_eff = b ^ op;
    assign sum   = a ^ b_eff ^ cin;
    assign cout  = (a & b_eff) | (a & cin) | (b_eff & cin);

endmodule : serial_fa_cell

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial adder/subtractor: one add/sub cell reused over WIDTH clocks, LSB first.
// Result, carry-out and overflow update together at the last RUN edge only.
module serial_addsub_ctrl
    import serial_addsub_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, a_sh_next;
    logic [WIDTH-1:0] b_sh_reg, b_sh_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             op_reg, op_next;
    logic             carry_reg, carry_next;
    logic             cout_reg, cout_next;
    logic             overflow_reg, overflow_next;

    logic             cell_sum;
    logic             cell_cout;

    serial_fa_cell u_cell (
        .a    (a_sh_reg[0]),
        .b    (b_sh_reg[0]),
        .op   (op_reg),
        .cin  (carry_reg),
        .sum  (cell_sum),
        .cout (cell_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            a_sh_reg     <= '0;
            b_sh_reg     <= '0;
            acc_reg      <= '0;
            result_reg   <= '0;
            cnt_reg      <= '0;
            op_reg       <= 1'b0;
            carry_reg    <= 1'b0;
            cout_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            a_sh_reg     <= a_sh_next;
            b_sh_reg     <= b_sh_next;
            acc_reg      <= acc_next;
            result_reg   <= result_next;
            cnt_reg      <= cnt_next;
            op_reg       <= op_next;
            carry_reg    <= carry_next;
            cout_reg     <= cout_next;
            overflow_reg <= overflow_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        a_sh_next     = a_sh_reg;
        b_sh_next     = b_sh_reg;
        acc_next      = acc_reg;
        result_next   = result_reg;
        cnt_next      = cnt_reg;
        op_next       = op_reg;
        carry_next    = carry_reg;
        cout_next     = cout_reg;
        overflow_next = overflow_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_sh_next  = a;
                    b_sh_next  = b;
                    op_next    = op;
                    // Seeding carry with op supplies the +1 of the two's-complement negate.
                    carry_next = (op == OP_SUB);
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                a_sh_next  = a_sh_reg >> 1;
                b_sh_next  = b_sh_reg >> 1;
                acc_next   = {cell_sum, acc_reg[WIDTH-1:1]};
                carry_next = cell_cout;
                cnt_next   = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_LAST) begin
                    // carry_reg here is the carry into the MSB cell.
                    result_next   = {cell_sum, acc_reg[WIDTH-1:1]};
                    cout_next     = cell_cout;
                    overflow_next = cell_cout ^ carry_reg;
                    cnt_next      = '0;
                    state_next    = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy     = (state_reg == RUN);
    assign done     = (state_reg == DONE);
    assign result   = result_reg;
    assign cout     = cout_reg;
    assign overflow = overflow_reg;

endmodule : serial_addsub_ctrl

// File: tb/tb_serial_addsub_ctrl.sv
// Directed self-checking bench for serial_addsub_ctrl at WIDTH=8.
// Each task drives one scenario and compares against hand-computed values.
module tb_serial_addsub_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    int n_cmp;
    int n_bad;

    serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request before an edge; returns 1ns after the capturing edge with start low.
    task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic opv);
        @(negedge clk);
        a     = av;
        b     = bv;
        op    = opv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Samples busy/done once per cycle, starting now (1ns after the capturing edge).
    task automatic observe(input int ncyc, input logic [7:0] prev_res,
                           output int busy_n, output int done_n,
                           output int done_first, output int done_second,
                           output int early_change);
        busy_n = 0; done_n = 0; done_first = -1; done_second = -1; early_change = 0;
        for (int k = 0; k < ncyc; k++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_first < 0) done_first = k;
                else if (done_second < 0) done_second = k;
            end
            if (k < WIDTH && result !== prev_res) early_change++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_op(input string name, input logic [7:0] av, input logic [7:0] bv,
                            input logic opv, input logic [7:0] exp_res,
                            input logic exp_cout, input logic exp_ovf);
        int bn, dn, d1, d2, ec;
        logic [7:0] prev;
        prev = result;
        start_op(av, bv, opv);
        observe(WIDTH + 3, prev, bn, dn, d1, d2, ec);
        n_cmp++;
        if (bn !== WIDTH) begin
            n_bad++;
            $display("FAIL %s busy_cycles got %0d want %0d", name, bn, WIDTH);
        end
        n_cmp++;
        if (dn !== 1 || d1 !== WIDTH) begin
            n_bad++;
            $display("FAIL %s done got count %0d at %0d want 1 at %0d", name, dn, d1, WIDTH);
        end
        n_cmp++;
        if (ec !== 0) begin
            n_bad++;
            $display("FAIL %s early_result_change got %0d want 0", name, ec);
        end
        n_cmp++;
        if (result !== exp_res || cout !== exp_cout || overflow !== exp_ovf) begin
            n_bad++;
            $display("FAIL %s outputs got res=%02h cout=%0b ovf=%0b want res=%02h cout=%0b ovf=%0b",
                     name, result, cout, overflow, exp_res, exp_cout, exp_ovf);
        end
        $display("op %s: %02h %s %02h -> res=%02h cout=%0b ovf=%0b", name, av,
                 opv ? "-" : "+", bv, result, cout, overflow);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl got busy=%0b done=%0b want 0 0", busy, done);
        end
        n_cmp++;
        if (result !== 8'h00 || cout !== 1'b0 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_data got res=%02h cout=%0b ovf=%0b want 00 0 0",
                     result, cout, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset got busy=%0b done=%0b want 0 0", busy, done);
        end
        $display("reset: busy=%0b done=%0b res=%02h", busy, done, result);
    endtask

    task automatic test_add();
        check_op("add", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        check_op("add_ovf", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        check_op("add_carry", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_sub();
        check_op("sub_borrow", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        check_op("sub_ovf", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    endtask

    task automatic test_ignore_busy();
        int bn, dn, d1, d2;
        start_op(8'h10, 8'h20, 1'b0);
        bn = 0; dn = 0; d1 = -1; d2 = -1;
        for (int k = 0; k < WIDTH + 8; k++) begin
            if (busy) bn++;
            if (done) begin
                dn++;
                if (d1 < 0) d1 = k;
            end
            if (k == 3) begin
                start = 1'b1;
                a     = 8'hAA;
                b     = 8'h55;
                op    = 1'b1;
            end
            if (k == WIDTH) start = 1'b0;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (bn !== WIDTH || dn !== 1 || d1 !== WIDTH) begin
            n_bad++;
            $display("FAIL ignore_busy got busy=%0d done=%0d at %0d want %0d 1 at %0d",
                     bn, dn, d1, WIDTH, WIDTH);
        end
        n_cmp++;
        if (result !== 8'h30 || cout !== 1'b0 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore_busy_res got res=%02h cout=%0b ovf=%0b want 30 0 0",
                     result, cout, overflow);
        end
        $display("ignore_busy: busy=%0d done=%0d res=%02h", bn, dn, result);
    endtask

    task automatic test_reset_mid();
        int bn, dn, d1, d2, ec;
        start_op(8'h3C, 8'h05, 1'b0);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00 || cout !== 1'b0 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid got busy=%0b done=%0b res=%02h cout=%0b ovf=%0b want 0 0 00 0 0",
                     busy, done, result, cout, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        observe(WIDTH + 4, 8'h00, bn, dn, d1, d2, ec);
        n_cmp++;
        if (bn !== 0 || dn !== 0) begin
            n_bad++;
            $display("FAIL reset_mid_quiet got busy=%0d done=%0d want 0 0", bn, dn);
        end
        $display("reset_mid: busy=%0d done=%0d res=%02h", bn, dn, result);
        check_op("after_reset", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int bn, dn, d1, d2, ec;
        @(negedge clk);
        a     = 8'h01;
        b     = 8'h01;
        op    = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        observe(3 * (WIDTH + 2), 8'h41, bn, dn, d1, d2, ec);
        start = 1'b0;
        n_cmp++;
        if (dn !== 3 || d1 !== WIDTH || d2 !== 2 * WIDTH + 2) begin
            n_bad++;
            $display("FAIL back_to_back_done got count=%0d at %0d,%0d want 3 at %0d,%0d",
                     dn, d1, d2, WIDTH, 2 * WIDTH + 2);
        end
        n_cmp++;
        if (bn !== 3 * WIDTH) begin
            n_bad++;
            $display("FAIL back_to_back_busy got %0d want %0d", bn, 3 * WIDTH);
        end
        n_cmp++;
        if (result !== 8'h02 || cout !== 1'b0 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL back_to_back_res got res=%02h cout=%0b ovf=%0b want 02 0 0",
                     result, cout, overflow);
        end
        $display("back_to_back: busy=%0d done=%0d res=%02h", bn, dn, result);
        repeat (WIDTH + 4) @(posedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_add();
        test_overflow();
        test_sub();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_serial_addsub_ctrl
